// File: rtl/tx_source_arbiter_pkg.sv
// Shared constants for the TX source arbiter and the TX datapath top:
// source-select mode encodings and the channel-index width helper.
package tx_source_arbiter_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tx_source_arbiter_if.sv
// Source-side and output-side handshake bundle of the TX source arbiter.
interface tx_source_arbiter_if
    import tx_source_arbiter_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_ch;

    // Sources and downstream sink.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    // The arbiter itself.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/tx_source_arbiter_rr_grant.sv
// Rotating priority encoder: picks the first valid channel after last_grant,
// wrapping modulo NUM_CH.
module rr_grant
    import tx_source_arbiter_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid,
    input  logic [SEL_W-1:0]  last_grant,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_exists
);

    int idx;

    // Scan from the lowest priority down so the nearest channel after
    // last_grant is written last and wins.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        idx          = 0;
        grant        = '0;
        grant_exists = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (valid[idx[SEL_W-1:0]]) begin
                grant        = idx[SEL_W-1:0];
                grant_exists = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_source_arbiter.sv
// Selects one of NUM_CH sources (fixed select or round-robin) and loads its
// word into a one-entry output register feeding the UART transmit path.
module tx_source_arbiter
    import tx_source_arbiter_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  mode_e                mode,
    input  logic [SEL_W-1:0]     sel,
    tx_source_arbiter_if.slave   bus
);

    logic [WIDTH-1:0]  words [NUM_CH];
    logic [SEL_W-1:0]  last_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_exists;
    logic [SEL_W-1:0]  grant;
    logic              grant_exists;
    logic              load_ok;
    logic              xfer;
    logic [NUM_CH-1:0] ready_vec;

    rr_grant #(.NUM_CH(NUM_CH)) u_rr_grant (
        .valid        (bus.in_valid),
        .last_grant   (last_grant),
        .grant        (rr_idx),
        .grant_exists (rr_exists)
    );

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            words[k] = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    // An out-of-range sel never grants, even when it aliases a real channel.
    always_comb begin
        grant        = '0;
        grant_exists = 1'b0;
        if (mode == MODE_RR) begin
            grant        = rr_idx;
            grant_exists = rr_exists;
        end else if (int'(sel) < NUM_CH) begin
            grant        = sel;
            grant_exists = bus.in_valid[sel];
        end
    end

    assign load_ok = enable & (~bus.out_valid | bus.out_ready);
    assign xfer    = load_ok & grant_exists & rst;

    always_comb begin
        ready_vec = '0;
        if (xfer) ready_vec[grant] = 1'b1;
    end

    assign bus.in_ready = ready_vec;

    // A load replaces the held word in the same edge it drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.out_valid <= 1'b0;
            last_grant    <= SEL_W'(NUM_CH - 1);
        end else if (xfer) begin
            bus.out_data  <= words[grant];
            bus.out_ch    <= grant;
            bus.out_valid <= 1'b1;
            last_grant    <= grant;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/tx_source_arbiter.md
Name: tx_source_arbiter

Overview:
- Parametrised successor to the fixed 4:1 TX source multiplexer.
- Selects one of NUM_CH data sources and transfers its word into a one-entry registered output stage that feeds the UART transmit path.
- Adds per-channel valid/ready handshakes, a software-select or round-robin mode, and a working enable.
- The output stage sustains one word per cycle with 1-cycle latency.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_CH, 4, number of source channels (2..16).
- SEL_W, $clog2(NUM_CH), width of the channel index; derived local constant, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  when 1, new words may be accepted; when 0, no grants are issued.
- mode  input  1  0 = fixed select by sel; 1 = round-robin arbitration.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  NUM_CH*WIDTH  flattened source words; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel word-available flags.
- in_ready  output  NUM_CH  per-channel accept strobe; one-hot or zero.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  out_data holds an untransferred word.
- out_ready  input  1  downstream (UART TX) accepts out_data this cycle.
- out_ch  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last_grant=NUM_CH-1, so channel 0 has first priority.
  - in_ready is 0 while reset is asserted.
- Load condition: load_ok = enable & (~out_valid | out_ready).
- Grant selection (combinational):
  - mode=0: grant = sel when sel < NUM_CH and in_valid[sel]=1; otherwise no grant. An out-of-range sel never grants.
  - mode=1: grant = first channel with in_valid=1, scanning last_grant+1, last_grant+2, ... with modulo-NUM_CH wrap. No valid channel means no grant.
- in_ready[grant] = load_ok & grant_exists. All other in_ready bits are 0.
  - in_ready depends combinationally on in_valid, sel, mode, enable, out_valid and out_ready.
  - in_ready never depends on in_data.
- Transfer into the output stage occurs when in_valid[k] & in_ready[k]. On the next edge:
  - out_data <= channel k word;
  - out_ch <= k;
  - out_valid <= 1;
  - last_grant <= k (updated only on a transfer, in either mode).
- Drain: if out_valid & out_ready and there is no transfer the same cycle, then out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load: the new word replaces the old in the same edge, out_valid stays 1, and throughput is 1 word/cycle.
- Stall: while out_valid & ~out_ready, out_data, out_ch and out_valid are held stable, and all in_ready are 0.
- enable=0: all in_ready are 0 and no grant is issued; the already-registered word still drains normally.
- Mode or sel change: takes effect in the same cycle for grant selection. It never alters a word already registered, and last_grant is retained.
- Latency: a source word appears on out_data one cycle after its handshake.
- No word is duplicated or dropped. Each handshake produces exactly one output transfer.
- Reset asserted mid-operation: a held word is discarded, and outputs return to their reset values immediately.

Decomposition:
- No shared package is needed.
- SEL_W, the mode encodings (MODE_FIXED=1'b0, MODE_RR=1'b1) and the flattened-bus slicing helper go in a small include/constant file shared with the TX datapath top.
- One natural sub-module: rr_grant, a combinational NUM_CH-wide rotating priority encoder. Inputs are in_valid and last_grant; outputs are grant index and grant_exists.
- The output register, load logic and last_grant register stay in tx_source_arbiter.

Test Plan:
- Reset: rst=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. After release with mode=1 and out_ready=1, the first grant is ch0, and out_ch=0 on the next cycle.
- Fixed mode: mode=0, sel=2, in_valid=4'b1111, ch2 word 32'hA5A5_0002, out_ready=1 -> in_ready=4'b0100, and the next cycle gives out_data=32'hA5A5_0002, out_ch=2.
- Fixed mode, channel not ready: mode=0, sel=2, in_valid=4'b1011 -> in_ready=0 and no transfer. Other valid channels are ignored.
- Round-robin fairness: mode=1, all channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, with out_valid continuously 1.
- Round-robin skip and wrap: last_grant=2, in_valid=4'b0011 -> grant ch0, then ch1, then ch0. Channels 2 and 3 are never granted.
- Backpressure and enable: a word is held with out_ready=0 for 5 cycles -> out_data and out_ch stay stable and in_ready=0.
  - Then set enable=0 and out_ready=1 -> the held word drains, out_valid drops to 0, and no new grant occurs until enable returns to 1.
